mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two cache controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Each controller issues a one-cycle memory strobe with a read/write flag; the arbiter captures it, grants the memory in turn and drives the memory strobe.
- It times the memory access with a fixed wait-state count, then returns a one-cycle ready pulse, plus read data on reads.
- Sits between the cache controllers' MStrobe/MRW outputs and main memory.

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- WAIT_CYCLES, 4, memory access wait states; legal range 1..255.
- CW, 8, wait counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_strobe  in  1  I-cache memory request pulse, one cycle.
- req0_rw  in  1  1 = write, 0 = read; sampled with req0_strobe.
- req0_addr  in  AW  request address; sampled with req0_strobe.
- req0_wdata  in  DW  write data; sampled with req0_strobe.
- req0_ready  out  1  one-cycle completion pulse to requester 0.
- req1_strobe, req1_rw, req1_addr, req1_wdata, req1_ready  same as requester 0, for the D-cache.
- rdata  out  DW  read data for the completing request.
- grant  out  2  one-hot owner of the memory port; 00 when idle.
- mem_strobe  out  1  one-cycle memory access start.
- mem_rw  out  1  write flag to memory.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pending bits 0, capture registers 0, wait counter 0, round-robin pointer set so requester 0 wins the first tie.
- Reset mid-operation: the in-flight access is abandoned and no ready pulse is issued.
- Capture: reqN_strobe=1 while pendingN=0 sets pendingN and loads rw/addr/wdata into that requester's capture register.
  - A strobe while pendingN=1 is ignored (protocol error; no state change).
- Arbitration, evaluated in IDLE and in DONE:
  - Candidates are pending bits OR live strobes.
  - One candidate: it is granted.
  - Both: the requester not granted last wins (round-robin).
- FSM states:
  - IDLE: grant=00. Any candidate -> ISSUE.
  - ISSUE: grant one-hot, mem_strobe=1. Counter loads WAIT_CYCLES. -> WAIT.
  - WAIT: decrement the counter each cycle; when counter==1 -> DONE.
    - WAIT lasts exactly WAIT_CYCLES cycles.
    - On a read, the edge leaving WAIT captures mem_rdata into rdata.
  - DONE: reqN_ready=1 for the granted N; pendingN is cleared; the pointer is updated. Any other candidate -> ISSUE, else -> IDLE.
- Outputs while granted (ISSUE, WAIT, DONE):
  - mem_rw, mem_addr and mem_wdata are driven from the granted capture register.
  - Outside a grant they are 0.
- Latency: strobe in cycle 0 with the arbiter idle -> mem_strobe in cycle 1 -> ready in cycle 2+WAIT_CYCLES (cycle 6 at default).
- rdata: held until the next read capture. Writes do not change rdata.
- Same-cycle strobe while DONE for the same requester: accepted as a new pending request, because the pending clear and the new set combine to set.
- Back-to-back: DONE -> ISSUE with no IDLE bubble.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: requester 1 (D-cache) always wins ties and the round-robin pointer is removed. Starvation of requester 0 is accepted.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - requester index constants REQ_I=0, REQ_D=1;
  - default WAIT_CYCLES.
- Sub-module arb_req_capture holds the pending bit plus rw/addr/wdata registers for one requester. It is instantiated twice.

Test Plan:
- Reset, then req0 read addr 0x0040 in cycle 0, mem_rdata=0xDEADBEEF:
  - mem_strobe=1 and grant=01 in cycle 1;
  - req0_ready pulse in cycle 6 with rdata=0xDEADBEEF.
- Same-cycle req0 read 0x0010 and req1 write 0x0020/0x12345678:
  - req0 served first (ready cycle 6);
  - req1 ISSUE in cycle 7 with mem_rw=1, mem_addr=0x0020, mem_wdata=0x12345678;
  - req1_ready in cycle 12.
- Repeated simultaneous requests: grants alternate 01, 10, 01, 10.
  - With MEM_ARB_FIXED_PRIO_EN: req1 wins every tie.
- Extra req0 strobe while req0 is pending: ignored; exactly one req0_ready; original address kept.
- reset deasserted->asserted (driven 0) during WAIT:
  - all outputs 0 immediately;
  - no ready pulse;
  - a new request after release completes normally.
- WAIT_CYCLES=1 build: req1 read -> req1_ready exactly 3 cycles after the strobe.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encoding,
// requester indices and the default memory wait-state count.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  localparam int DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// Handshake: reqN_strobe is a one-cycle request carrying rw/addr/wdata; reqN_ready
// is a one-cycle completion pulse with rdata valid in that cycle for reads.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);

  logic          req0_strobe;
  logic          req0_rw;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ready;

  logic          req1_strobe;
  logic          req1_rw;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;

  logic [DW-1:0] rdata;
  logic [1:0]    grant;

  logic          mem_strobe;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    dbg_state;

  modport master (
    output req0_strobe, req0_rw, req0_addr, req0_wdata,
    output req1_strobe, req1_rw, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready, rdata, grant,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata, dbg_state
  );

  modport slave (
    input  req0_strobe, req0_rw, req0_addr, req0_wdata,
    input  req1_strobe, req1_rw, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready, rdata, grant,
    output mem_strobe, mem_rw, mem_addr, mem_wdata, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_capture.sv
// One requester's pending flag and captured rw/addr/wdata. A strobe in the same
// cycle as the clear of a completing request is accepted as a new request.
module arb_req_capture #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strobe_i,
  input  logic          rw_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          clear_i,
  output logic          pending_o,
  output logic          rw_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o
);

  logic          pending_q, pending_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          accept;

  always_comb begin
    accept    = strobe_i && (!pending_q || clear_i);
    pending_d = accept || (pending_q && !clear_i);
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (accept) begin
      rw_d    = rw_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pending_o = pending_q;
  assign rw_o      = rw_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester main-memory port arbiter (I-cache = 0, D-cache = 1) with fixed wait states.
// Define MEM_ARB_FIXED_PRIO_EN to make the D-cache win every tie instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CW          = 8
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]    state_q, state_d;
  logic          cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    pend, cap_rw, strobe, clear, cand;
  logic [AW-1:0] cap_addr0, cap_addr1;
  logic [DW-1:0] cap_wd0, cap_wd1;
  logic          tie_win;
  logic          granted;

  assign strobe = {bus.req1_strobe, bus.req0_strobe};
  assign clear  = {(state_q == S_DONE) &&  cur_q, (state_q == S_DONE) && !cur_q};
  assign cand   = pend | strobe;

  arb_req_capture #(.AW(AW), .DW(DW)) u_cap_i (
    .clk      (clk),
    .rst_n    (reset),
    .strobe_i (bus.req0_strobe),
    .rw_i     (bus.req0_rw),
    .addr_i   (bus.req0_addr),
    .wdata_i  (bus.req0_wdata),
    .clear_i  (clear[REQ_I]),
    .pending_o(pend[REQ_I]),
    .rw_o     (cap_rw[REQ_I]),
    .addr_o   (cap_addr0),
    .wdata_o  (cap_wd0)
  );

  arb_req_capture #(.AW(AW), .DW(DW)) u_cap_d (
    .clk      (clk),
    .rst_n    (reset),
    .strobe_i (bus.req1_strobe),
    .rw_i     (bus.req1_rw),
    .addr_i   (bus.req1_addr),
    .wdata_i  (bus.req1_wdata),
    .clear_i  (clear[REQ_D]),
    .pending_o(pend[REQ_D]),
    .rw_o     (cap_rw[REQ_D]),
    .addr_o   (cap_addr1),
    .wdata_o  (cap_wd1)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_win = 1'(REQ_D);
`else
  // last_q holds the requester granted most recently; reset to D so I wins the first tie.
  logic last_q, last_d;
  assign last_d  = (state_q == S_DONE) ? cur_q : last_q;
  assign tie_win = ~last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'(REQ_D);
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          state_d = S_ISSUE;
          cur_d   = (&cand) ? tie_win : cand[1];
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(WAIT_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (!cap_rw[cur_q]) rdata_d = bus.mem_rdata;
        end
      end
      S_DONE: begin
        // Only the other requester can chain straight into ISSUE; a fresh strobe
        // from the finishing requester waits one IDLE cycle.
        if (cand[~cur_q]) begin
          state_d = S_ISSUE;
          cur_d   = ~cur_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cur_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign granted        = (state_q != S_IDLE);
  assign bus.grant      = granted ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_strobe = (state_q == S_ISSUE);
  assign bus.mem_rw     = granted && cap_rw[cur_q];
  assign bus.mem_addr   = granted ? (cur_q ? cap_addr1 : cap_addr0) : '0;
  assign bus.mem_wdata  = granted ? (cur_q ? cap_wd1 : cap_wd0) : '0;
  assign bus.req0_ready = (state_q == S_DONE) && (cur_q == 1'(REQ_I));
  assign bus.req1_ready = (state_q == S_DONE) && (cur_q == 1'(REQ_D));
  assign bus.rdata      = rdata_q;
  assign bus.dbg_state  = state_q;

endmodule
